// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Instruction-memory fetch bus (request/ready handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : MIPS instruction-fetch stage with PC, IF/ID register and
//                a one-entry skid buffer for fetches completing under stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall_i,
    input  wire logic        flush_i,
    input  wire logic        redirect_valid_i,
    input  wire logic [31:0] redirect_pc_i,
    if_stage_if.master       imem,
    output logic [31:0]      pc_o,
    output logic             if_id_valid_o,
    output logic [31:0]      if_id_instr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      fetch_count_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic [31:0] count_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc4_q;

    logic [31:0] w_pc_inc;

    assign w_pc_inc      = pc_q + 32'd4;
    assign imem.req      = req_q;
    assign imem.addr     = pc_q;
    assign pc_o          = pc_q;
    assign if_id_valid_o = valid_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign fetch_count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'd0;
            count_q      <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'd0;
        end else if (redirect_valid_i) begin
            // Redirect wins over stall: any response this cycle and the skid are dropped.
            pc_q    <= redirect_pc_i & ~32'd3;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    if (flush_i) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'd0;
                    end
                end
                S_FETCH: begin
                    if (flush_i) begin
                        // Squashed fetch is still consumed so the PC moves past it.
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'd0;
                        if (imem.ready) begin
                            pc_q <= w_pc_inc;
                        end
                    end else if (imem.ready) begin
                        if (stall_i) begin
                            skid_instr_q <= imem.rdata;
                            skid_pc4_q   <= w_pc_inc;
                            state_q      <= S_HOLD;
                            req_q        <= 1'b0;
                        end else begin
                            valid_q <= 1'b1;
                            instr_q <= imem.rdata;
                            pc4_q   <= w_pc_inc;
                            pc_q    <= w_pc_inc;
                            count_q <= count_q + 32'd1;
                        end
                    end else if (!stall_i) begin
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (flush_i) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'd0;
                        pc_q    <= w_pc_inc;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end else if (!stall_i) begin
                        valid_q <= 1'b1;
                        instr_q <= skid_instr_q;
                        pc4_q   <= skid_pc4_q;
                        pc_q    <= w_pc_inc;
                        count_q <= count_q + 32'd1;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode in `datapath`. Owns the program counter and issues word fetches to instruction memory over a req/ready handshake. Loads the IF/ID pipeline register and responds to stall, flush and branch/jump redirects from later stages. Holds a one-entry skid buffer so that a fetch completing during a stall is never lost.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0000: bubble encoding (`sll $0,$0,0`) written to IF/ID on flush or reset.

**Ports**
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `stall` input 1: hazard-unit hold. Freezes PC and IF/ID.
- `flush` input 1: squashes the IF/ID contents.
- `redirect_valid` input 1: a taken branch/jump from EX.
- `redirect_pc` input 32: target address. Bits [1:0] are forced to 0.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address, always equal to `pc` while `imem_req`=1.
- `imem_ready` input 1: `imem_rdata` is valid this cycle for the current request.
- `imem_rdata` input 32: fetched instruction.
- `pc` output 32: current fetch PC.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `if_id_instr` output 32: IF/ID instruction.
- `if_id_pc4` output 32: IF/ID PC+4.
- `fetch_count` output 32: number of instructions delivered to IF/ID. Wraps modulo 2^32.

## Operation

- **States:** BOOT, FETCH, HOLD.
- **BOOT** (entered on reset): `imem_req`=0. Moves unconditionally to FETCH on the next edge.
- **FETCH:** `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ready` & !`stall`: IF/ID <= {1, `imem_rdata`, `pc`+4}; `pc` <= `pc`+4; `fetch_count`++. Stay in FETCH.
  - `imem_ready` & `stall`: skid <= {`imem_rdata`, `pc`+4}; IF/ID unchanged; `pc` unchanged; go to HOLD.
  - !`imem_ready`: wait in FETCH. On the next edge with !`stall`, IF/ID valid <= 0 (bubble). IF/ID is held while `stall`=1.
- **HOLD:** `imem_req`=0.
  - When `stall` drops: IF/ID <= {1, skid}; `pc` <= `pc`+4; `fetch_count`++; go to FETCH.
- **Priority, highest first:** `rst` > `redirect_valid` > `flush` > `stall` > normal.
- **Redirect:**
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - IF/ID <= {0, `NOP_INSTR`, 0}.
  - Skid is discarded.
  - Any `imem_ready` response in the same cycle is dropped.
  - State <= FETCH.
  - `stall` is ignored in that cycle.
- **Flush without redirect:** IF/ID <= bubble. PC and state follow the normal rules, except the instruction that would have entered IF/ID this cycle is still consumed (PC advances), not buffered.
- **Arithmetic:** PC+4 wraps modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000.

## Timing

- **Reset values:**
  - `pc`=`RESET_PC`
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0
  - `fetch_count`=0
  - state=BOOT
- **Reset mid-operation** immediately clears everything to the reset values. The first request is issued in the second cycle after `rst` deasserts.
- **Latency:** instruction appears on `if_id_*` on the edge where `imem_ready`=1 (zero-wait memory gives 1 instr/cycle).
- **Handshake:** `imem_addr` is stable while `imem_req`=1 until `imem_ready` or a redirect. `imem_ready` while `imem_req`=0 is ignored.
- **Stall:** all outputs hold on every stalled edge, except the FETCH→HOLD capture.
- **Redirect:** the first fetch of the target is issued in the cycle after `redirect_valid`.

## Test plan

1. **Reset and streaming:** `rst` pulsed for 10 ns, zero-wait memory returning `addr`^32'hA5A5_0000. Required:
   - `pc` sequence 0, 0 (BOOT), 4, 8.
   - `if_id_instr`=32'hA5A5_0000 with `if_id_pc4`=4, then 32'hA5A5_0004.
   - `fetch_count`=2 after two deliveries.
2. **Wait states:** `imem_ready` low for 2 cycles at `pc`=8. Required:
   - `imem_addr` stays 8.
   - `if_id_valid`=0 for 2 cycles.
   - Then `if_id_instr` is the word at 8 and `pc`=12.
3. **Stall with skid:** `stall`=1 for 3 cycles while the fetch at 12 completes. Required:
   - IF/ID is unchanged during the stall.
   - `imem_req`=0 in HOLD.
   - After release, `if_id_pc4`=16 and `pc`=16, with no duplicate or lost instruction (compare against `fetch_count`).
4. **Redirect with stall:** `redirect_valid`=1, `redirect_pc`=32'h0000_0103, `stall`=1, `imem_ready`=1 in the same cycle. Required:
   - `pc`=32'h100 and `if_id_valid`=0 next cycle.
   - Response dropped, `fetch_count` unchanged.
   - The next fetch has `imem_addr`=32'h100.
5. **Wrap-around and async reset:**
   - Redirect to 32'hFFFF_FFFC, then fetch. Required: `pc` becomes 0 and `if_id_pc4`=0.
   - Assert `rst` asynchronously mid-cycle during HOLD. Required: all outputs reach their reset values before the next clock edge.
